// File: rtl/q_cycle_sequencer.sv
// Four-phase instruction sequencer: Q1..Q4 phase ring, PC, IR load and circular return stack.
// Optional sleep/wake support is compiled in with `define SEQ_SLEEP_EN.
module q_cycle_sequencer #(
  parameter int PCW         = 10,
  parameter int IW          = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [IW-1:0]  prog_data,
  input  logic           jump,
  input  logic           call,
  input  logic           ret,
  input  logic           skip,
  input  logic [PCW-1:0] target,
  input  logic           sleep_req,
  input  logic           wake,
  output logic           clk1,
  output logic           clk2,
  output logic           clk3,
  output logic           clk4,
  output logic [PCW-1:0] prog_addr,
  output logic [IW-1:0]  inst_reg,
  output logic           exec_valid,
  output logic           stk_ovf,
  output logic           stk_unf,
  output logic           asleep
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int CW  = $clog2(STACK_DEPTH + 1);

  localparam logic [3:0] PH_IDLE = 4'b0000;
  localparam logic [3:0] PH_Q1   = 4'b0001;
  localparam logic [3:0] PH_Q2   = 4'b0010;
  localparam logic [3:0] PH_Q3   = 4'b0100;
  localparam logic [3:0] PH_Q4   = 4'b1000;

  localparam logic [CW-1:0] CNT_FULL = CW'(STACK_DEPTH);

  logic [3:0]     r_phase;
  logic [PCW-1:0] r_pc;
  logic [IW-1:0]  r_ir;
  logic           r_ev;
  logic [PCW-1:0] r_stk [STACK_DEPTH];
  logic [SPW-1:0] r_sp;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;
  logic           r_unf;
  logic           r_asleep;

  logic [3:0]     w_phase_nxt;
  logic           w_adv;
  logic           w_q4;
  logic           w_take_ret;
  logic           w_take_call;
  logic           w_take_jump;
  logic           w_take_skip;
  logic           w_take_sleep;
  logic           w_wake;
  logic           w_flush;
  logic [PCW-1:0] w_pc_inc;
  logic [SPW-1:0] w_sp_dec;
  logic [PCW-1:0] w_pop_data;

`ifdef SEQ_SLEEP_EN
  assign w_adv        = run && !r_asleep;
  assign w_wake       = r_asleep && run && wake;
  assign w_take_sleep = w_q4 && r_ev && !ret && !call && !jump && !skip && sleep_req;
`else
  logic w_unused_sleep;
  assign w_unused_sleep = sleep_req | wake;
  assign w_adv          = run;
  assign w_wake         = 1'b0;
  assign w_take_sleep   = 1'b0;
`endif

  // Requests are honoured only at the Q4 edge of a non-bubble cycle; ret > call > jump > skip.
  assign w_q4        = w_adv && (r_phase == PH_Q4);
  assign w_take_ret  = w_q4 && r_ev && ret;
  assign w_take_call = w_q4 && r_ev && !ret && call;
  assign w_take_jump = w_q4 && r_ev && !ret && !call && jump;
  assign w_take_skip = w_q4 && r_ev && !ret && !call && !jump && skip;
  assign w_flush     = w_take_ret | w_take_call | w_take_jump | w_take_skip;

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_sp_dec   = r_sp - 1'b1;
  assign w_pop_data = r_stk[w_sp_dec];

  always_comb begin
    w_phase_nxt = PH_Q1;
    case (r_phase)
      PH_IDLE: w_phase_nxt = PH_Q1;
      PH_Q1:   w_phase_nxt = PH_Q2;
      PH_Q2:   w_phase_nxt = PH_Q3;
      PH_Q3:   w_phase_nxt = PH_Q4;
      PH_Q4:   w_phase_nxt = PH_Q1;
      default: w_phase_nxt = PH_Q1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_take_call) r_stk[r_sp] <= r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_ev     <= 1'b0;
      r_sp     <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_asleep <= 1'b0;
    end else if (w_wake) begin
      r_phase  <= PH_Q1;
      r_asleep <= 1'b0;
      r_ev     <= 1'b0;
    end else if (w_adv) begin
      r_phase <= w_take_sleep ? PH_IDLE : w_phase_nxt;
      if (w_take_sleep) r_asleep <= 1'b1;
      if (w_q4) begin
        r_ir <= prog_data;
        r_ev <= !w_flush;
        if (w_take_ret)                      r_pc <= w_pop_data;
        else if (w_take_call || w_take_jump) r_pc <= target;
        else                                 r_pc <= w_pc_inc;
      end
      // A full stack keeps its count; the push overwrites the oldest entry.
      if (w_take_call) begin
        r_sp <= r_sp + 1'b1;
        if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
        else                   r_cnt <= r_cnt + 1'b1;
      end else if (w_take_ret) begin
        r_sp <= w_sp_dec;
        if (r_cnt == '0) r_unf <= 1'b1;
        else             r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // exec_valid=1 means inst_reg holds a real instruction for the whole Q1..Q4 cycle; 0 marks a bubble.
  assign clk1       = r_phase[0];
  assign clk2       = r_phase[1];
  assign clk3       = r_phase[2];
  assign clk4       = r_phase[3];
  assign prog_addr  = r_pc;
  assign inst_reg   = r_ir;
  assign exec_valid = r_ev;
  assign stk_ovf    = r_ovf;
  assign stk_unf    = r_unf;
  assign asleep     = r_asleep;

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Directed bench for q_cycle_sequencer: driver pushes the expected cycle into a queue at each Q1,
// a monitor pops and compares; phase, hold, stack-flag and reset checks are made inline.
module tb_q_cycle_sequencer;
  localparam int PCW = 10;
  localparam int IW  = 8;
  localparam int W   = PCW + 1 + IW;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_SKIP = 4'b0001;
  localparam logic [3:0] C_JUMP = 4'b0010;
  localparam logic [3:0] C_CALL = 4'b0100;
  localparam logic [3:0] C_RET  = 4'b1000;

  logic           clk = 1'b0;
  logic           rst_n, run, jump, call, ret, skip, sleep_req, wake;
  logic [PCW-1:0] target;
  logic [IW-1:0]  prog_data;
  logic           clk1, clk2, clk3, clk4, exec_valid, stk_ovf, stk_unf, asleep;
  logic [PCW-1:0] prog_addr;
  logic [IW-1:0]  inst_reg;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   mon_e;
  int             n_checks = 0;
  int             n_pass   = 0;
  logic [PCW-1:0] ra [1:9];
  logic [PCW-1:0] pa, ia, tg, rr;

  q_cycle_sequencer #(.PCW(PCW), .IW(IW), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_data(prog_data),
    .jump(jump), .call(call), .ret(ret), .skip(skip), .target(target),
    .sleep_req(sleep_req), .wake(wake),
    .clk1(clk1), .clk2(clk2), .clk3(clk3), .clk4(clk4),
    .prog_addr(prog_addr), .inst_reg(inst_reg), .exec_valid(exec_valid),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .asleep(asleep)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] memf(input logic [PCW-1:0] a);
    return a[7:0] ^ {a[9:8], 6'h2D};
  endfunction

  assign prog_data = memf(prog_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Waits for the next Q1, records the expected cycle, then presents the controls for its Q4 edge.
  task automatic step(input logic [3:0] ctl, input logic [PCW-1:0] tgt,
                      input logic [PCW-1:0] ea, input logic ev, input logic [PCW-1:0] ei);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clk1 && n < 12);
    if (!clk1) begin
      n_checks++;
      $display("FAIL step_timeout: clk1 not seen, expected cycle at addr %0h", ea);
    end else begin
      exp_q.push_back({ea, ev, memf(ei)});
    end
    {ret, call, jump, skip} = ctl;
    target = tgt;
  endtask

  always begin
    @(negedge clk);
    #1;
    if (clk1 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle_addr", prog_addr, mon_e[W-1 -: PCW]);
      check("cycle_valid", exec_valid, mon_e[IW]);
      if (mon_e[IW]) check("cycle_inst", inst_reg, mon_e[IW-1:0]);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phase"}, {clk4, clk3, clk2, clk1}, 4'b0000);
    check({tag, "_addr"}, prog_addr, 0);
    check({tag, "_inst"}, inst_reg, 0);
    check({tag, "_valid"}, exec_valid, 0);
    check({tag, "_ovf"}, stk_ovf, 0);
    check({tag, "_unf"}, stk_unf, 0);
    check({tag, "_asleep"}, asleep, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
    sleep_req = 1'b0; wake = 1'b0; target = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_phase", {clk4, clk3, clk2, clk1}, 4'b0000);

    // Phase ring and first (bubble) instruction cycle.
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("ring_phase", {clk4, clk3, clk2, clk1}, 32'(4'b0001 << ((i - 1) % 4)));
      check("ring_addr", prog_addr, (i <= 4) ? 0 : 1);
      check("ring_valid", exec_valid, (i <= 4) ? 0 : 1);
    end
    check("ring_inst", inst_reg, memf(10'h000));

    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_phase", {clk4, clk3, clk2, clk1}, 4'b1000);
      check("hold_addr", prog_addr, 1);
      check("hold_valid", exec_valid, 1);
      check("hold_inst", inst_reg, memf(10'h000));
    end
    run = 1'b1;

    step(C_JUMP,          10'h010, 10'h002, 1'b1, 10'h001);
    step(C_NONE,          10'h000, 10'h010, 1'b0, 10'h000);
    step(C_CALL,          10'h050, 10'h011, 1'b1, 10'h010);
    step(C_NONE,          10'h000, 10'h050, 1'b0, 10'h000);
    step(C_RET,           10'h000, 10'h051, 1'b1, 10'h050);
    step(C_NONE,          10'h000, 10'h011, 1'b0, 10'h000);
    step(C_JUMP,          10'h120, 10'h012, 1'b1, 10'h011);
    step(C_NONE,          10'h000, 10'h120, 1'b0, 10'h000);
    step(C_JUMP,          10'h020, 10'h121, 1'b1, 10'h120);
    step(C_NONE,          10'h000, 10'h020, 1'b0, 10'h000);
    step(C_SKIP,          10'h000, 10'h021, 1'b1, 10'h020);
    step(C_NONE,          10'h000, 10'h022, 1'b0, 10'h000);
    step(C_JUMP | C_SKIP, 10'h3FE, 10'h023, 1'b1, 10'h022);
    step(C_JUMP,          10'h200, 10'h3FE, 1'b0, 10'h000);
    step(C_NONE,          10'h000, 10'h3FF, 1'b1, 10'h3FE);
    step(C_NONE,          10'h000, 10'h000, 1'b1, 10'h3FF);
    step(C_CALL | C_JUMP, 10'h100, 10'h001, 1'b1, 10'h000);
    step(C_NONE,          10'h000, 10'h100, 1'b0, 10'h000);
    step(C_RET | C_CALL,  10'h300, 10'h101, 1'b1, 10'h100);
    step(C_NONE,          10'h000, 10'h001, 1'b0, 10'h000);

    // Nine nested calls on an 8-deep stack: the ninth overwrites the first return address.
    pa = 10'h002;
    ia = 10'h001;
    for (int k = 1; k <= 9; k++) begin
      tg = 10'h080 + 10'(8 * k);
      ra[k] = pa;
      step(C_CALL, tg, pa, 1'b1, ia);
      step(C_NONE, 10'h000, tg, 1'b0, 10'h000);
      check("stk_ovf_after_call", stk_ovf, (k == 9) ? 1 : 0);
      check("stk_unf_after_call", stk_unf, 0);
      pa = tg + 1'b1;
      ia = tg;
    end

    for (int j = 1; j <= 9; j++) begin
      rr = (j <= 8) ? ra[10 - j] : ra[9];
      step(C_RET, 10'h000, pa, 1'b1, ia);
      step(C_NONE, 10'h000, rr, 1'b0, 10'h000);
      check("stk_unf_after_ret", stk_unf, (j == 9) ? 1 : 0);
      check("stk_ovf_sticky", stk_ovf, 1);
      pa = rr + 1'b1;
      ia = rr;
    end
    step(C_NONE, 10'h000, pa, 1'b1, ia);

    // Asynchronous reset in the middle of an instruction cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step(C_NONE, 10'h000, 10'h000, 1'b0, 10'h000);
    step(C_NONE, 10'h000, 10'h001, 1'b1, 10'h000);
    step(C_NONE, 10'h000, 10'h002, 1'b1, 10'h001);
    check("post_reset_ovf", stk_ovf, 0);
    check("post_reset_unf", stk_unf, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q_cycle_sequencer.md
Name: q_cycle_sequencer

Overview:
- Instruction sequencer for the 8-bit-instruction core.
- Generates the four one-hot phase enables clk1..clk4 consumed by the decoder and datapath.
- Owns the program counter, instruction-register load and the call/return stack.
- Inserts flush bubbles after taken skips, jumps, calls and returns, and sits between program memory and the decoder.

Parameters:
- PCW, 10, program counter / program address width
- IW, 8, instruction width
- STACK_DEPTH, 8, return-stack entries (power of two, ≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = advance phases; 0 = freeze all state
- prog_data  in  IW  program memory read data for prog_addr
- jump  in  1  execute-stage GOTO request
- call  in  1  execute-stage CALL request
- ret  in  1  execute-stage RETURN request
- skip  in  1  execute-stage skip-next condition true
- target  in  PCW  jump/call destination
- sleep_req  in  1  enter sleep (optional feature)
- wake  in  1  leave sleep (optional feature)
- clk1, clk2, clk3, clk4  out  1 each  registered one-hot phase enables Q1..Q4
- prog_addr  out  PCW  fetch address (= pc)
- inst_reg  out  IW  instruction being executed
- exec_valid  out  1  0 = current instruction cycle is a bubble
- stk_ovf  out  1  sticky: push while full
- stk_unf  out  1  sticky: pop while empty
- asleep  out  1  sequencer in sleep

Behaviour:
- Reset (async, rst_n=0):
  - clk1..clk4=0, pc=0, inst_reg=0, exec_valid=0.
  - Stack pointer=0, stack count=0, stk_ovf=0, stk_unf=0, asleep=0.
- Phase ring:
  - First rising clk with run=1 after reset gives clk1=1.
  - Each rising clk with run=1 advances Q1→Q2→Q3→Q4→Q1.
  - run=0 holds every register, including the phase.
  - Exactly one phase is high once started.
- Pipeline:
  - prog_addr = pc, stable across the whole instruction cycle.
  - At the clock edge ending Q4 (the "Q4 edge"), inst_reg ← prog_data and exec_valid ← 1 unless flushed. One-cycle fetch/execute overlap.
- Control sampling:
  - jump/call/ret/skip/target are sampled only at the Q4 edge and only when exec_valid=1. They are ignored otherwise.
  - Priority: ret > call > jump > skip.
- Updates at the Q4 edge:
  - No request: pc ← pc+1, modulo 2^PCW, so 2^PCW−1 wraps to 0.
  - jump: pc ← target; exec_valid ← 0.
  - call: push pc (already the return address); pc ← target; exec_valid ← 0.
  - ret: pop → pc; exec_valid ← 0.
  - skip: pc ← pc+1; exec_valid ← 0. The fetched instruction is discarded.
- Each taken event costs exactly one bubble cycle.
- After reset, the first instruction cycle is a bubble (exec_valid=0); address 0 executes in the second cycle.
- Stack:
  - Circular buffer with a STACK_DEPTH-entry pointer.
  - Push when count=STACK_DEPTH overwrites the oldest entry, keeps count, and sets stk_ovf.
  - Pop when count=0 still reads and decrements the pointer (wraps), leaves count=0, and sets stk_unf.
  - Sticky flags clear only on reset.
- Reset mid-cycle: immediate return to the reset state. Any partial fetch is dropped.

Optional Feature:
- Macro: SEQ_SLEEP_EN.
- Enabled:
  - sleep_req sampled at the Q4 edge (exec_valid=1, lowest priority, below skip) sets asleep=1 and clk1..clk4=0.
  - pc advances as normal.
  - While asleep, state is frozen until wake=1 and run=1. The next edge then gives clk1=1, asleep=0, exec_valid=0 (one wake bubble).
- Disabled: sleep_req and wake are ignored; asleep is tied to 0.

Test Plan:
- Reset then run=1 for 8 clocks → clk1..clk4 cycle 1,2,3,4,1,2,3,4; prog_addr 0 then 1; exec_valid 0 then 1; run=0 for 3 clocks → all outputs held.
- Straight-line from pc=0x3FE (PCW=10) → prog_addr sequence 0x3FE, 0x3FF, 0x000.
- jump with target=0x120 at the Q4 edge → next prog_addr=0x120; following cycle exec_valid=0; next cycle exec_valid=1 with inst_reg=mem[0x120].
- call target=0x050 from the instruction at 0x010, then ret at 0x050 → pc 0x050, then 0x011; one bubble after each.
- skip at pc=0x021 → instruction at 0x021 flushed (exec_valid=0); next executed instruction is 0x022; simultaneous jump+skip → jump wins.
- 9 calls with STACK_DEPTH=8 → stk_ovf=1; 9 returns → stk_unf=1 on the 9th; mid-sequence rst_n=0 → all outputs back to reset values immediately.
